// File: rtl/mem_bus_stage.sv
// Memory stage of a 5-stage pipeline: passes ALU results through, or runs one
// big-endian bus access (load/store) with an ack timeout and stalls upstream.
module mem_bus_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_W     = 32,
  parameter int TMO_CYC    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic                  whilo_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_data_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  whilo_o,
  output logic                  stall_req_o,
  output logic                  err_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [3:0]            bus_sel_o,
  output logic [31:0]           bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [31:0]           bus_rdata_i,
  output logic [1:0]            state_o
);

  // Bus handshake: bus_req_o rises with stable we/addr/sel/wdata and holds them
  // until the first cycle bus_ack_i is seen high; that cycle completes the
  // transfer and bus_rdata_i is sampled. Acks outside REQ are ignored.

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam int CNT_W = $clog2(TMO_CYC);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        op_q, op_d;
  logic              fail_q, fail_d;

  logic        is_load, is_store, is_half, is_word, misaligned;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;
  logic        done_is_load;

  always_comb begin
    is_load    = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
    is_store   = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    is_half    = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
    is_word    = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
    misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
  end

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    sel_c   = 4'b0000;
    wdata_c = mem_data_i;
    if (is_word) begin
      sel_c = 4'b1111;
    end else if (is_half) begin
      sel_c   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      wdata_c = {2{mem_data_i[15:0]}};
    end else begin
      case (mem_addr_i[1:0])
        2'b00:   sel_c = 4'b1000;
        2'b01:   sel_c = 4'b0100;
        2'b10:   sel_c = 4'b0010;
        default: sel_c = 4'b0001;
      endcase
      wdata_c = {4{mem_data_i[7:0]}};
    end
  end

  always_comb begin
    case (bus_addr_q[1:0])
      2'b00:   byte_c = rdata_q[31:24];
      2'b01:   byte_c = rdata_q[23:16];
      2'b10:   byte_c = rdata_q[15:8];
      default: byte_c = rdata_q[7:0];
    endcase
    half_c       = bus_addr_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    done_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);
    case (op_q)
      OP_LB:   load_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  load_c = {24'd0, byte_c};
      OP_LH:   load_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  load_c = {16'd0, half_c};
      default: load_c = rdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    op_d        = op_q;
    fail_d      = fail_q;
    case (state_q)
      S_IDLE: begin
        if ((is_load || is_store) && !misaligned) begin
          state_d     = S_REQ;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = mem_addr_i;
          bus_sel_d   = sel_c;
          bus_wdata_d = wdata_c;
          op_d        = mem_op_i;
          fail_d      = 1'b0;
        end
      end
      S_REQ: begin
        // Ack wins over timeout when both land in the same cycle.
        if (bus_ack_i) begin
          rdata_d   = bus_rdata_i;
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_W'(TMO_CYC - 1)) begin
          bus_req_d = 1'b0;
          fail_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= 4'b0000;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      op_q        <= 4'd0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      op_q        <= op_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    hi_o        = hi_i;
    lo_o        = lo_i;
    whilo_o     = whilo_i;
    stall_req_o = 1'b0;
    err_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_load || is_store) begin
          if (misaligned) begin
            err_o  = 1'b1;
            wreg_o = 1'b0;
          end else begin
            stall_req_o = 1'b1;
          end
        end
      end
      S_REQ: stall_req_o = 1'b1;
      default: begin
        if (fail_q) begin
          err_o  = 1'b1;
          wreg_o = 1'b0;
        end else if (done_is_load) begin
          wdata_o = load_c;
        end
      end
    endcase
    // Write-back sees a clean bubble while reset is held.
    if (!rst) begin
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
      hi_o        = 32'd0;
      lo_o        = 32'd0;
      whilo_o     = 1'b0;
      stall_req_o = 1'b0;
      err_o       = 1'b0;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;
  assign state_o     = state_q;

endmodule
